// File: rtl/imem_boot_controller_pkg.sv
// Shared constants for the instruction-memory boot controller.
// FSM encoding, default address width and the idle instruction.
package imem_boot_controller_pkg;

  localparam int N_DEF = 8;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  localparam logic [1:0] HALT  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] RUN   = 2'd3;

endpackage

// File: rtl/imem_boot_controller_if.sv
// Loader, CPU fetch and instruction-memory bus bundle.
// master = controller side, slave = loader/CPU/memory side.
interface imem_boot_controller_if #(
  parameter int N = 8
);
  logic        ld_valid;
  logic [7:0]  ld_data;
  logic        ld_ready;
  logic [N-1:0] cpu_pc;
  logic [31:0] cpu_instr;
  logic        cpu_rst_n;
  logic [N-1:0] mem_a;
  logic [31:0] mem_rd;
  logic        mem_we;
  logic [31:0] mem_wd;

  modport master (
    input  ld_valid, ld_data, cpu_pc, mem_rd,
    output ld_ready, cpu_instr, cpu_rst_n,
    output mem_a, mem_we, mem_wd
  );

  modport slave (
    output ld_valid, ld_data, cpu_pc, mem_rd,
    input  ld_ready, cpu_instr, cpu_rst_n,
    input  mem_a, mem_we, mem_wd
  );
endinterface

// File: rtl/imem_word_assembler.sv
// Packs loader bytes little-endian into a 32-bit word.
// last flags the transfer that completes the word.
module imem_word_assembler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        xfer,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        last
);
  logic [1:0] byte_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= 2'd0;
      word     <= 32'd0;
    end else if (clr) begin
      byte_cnt <= 2'd0;
    end else if (xfer) begin
      word[{byte_cnt, 3'b000} +: 8] <= data;
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

  assign last = xfer && (byte_cnt == 2'd3);

endmodule

// File: rtl/imem_boot_controller.sv
// Boot loader: streams bytes into instruction memory, then
// releases the CPU and serves its fetches from that memory.
module imem_boot_controller
  import imem_boot_controller_pkg::*;
#(
  parameter int          N   = N_DEF,
  parameter logic [31:0] NOP = NOP_INSTR
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         boot_req,
  input  logic [N-2:0] ld_len,
  imem_boot_controller_if.master bus,
  output logic         busy,
  output logic         done,
  output logic         err
);
  localparam int W = N - 2;
  localparam logic [N-2:0] MAX_LEN = {1'b1, {W{1'b0}}};

  logic [1:0]   state;
  logic [W-1:0] word_idx;
  logic [N-2:0] len_q;
  logic [N-2:0] next_cnt;
  logic [31:0]  word;
  logic         last;
  logic         xfer;
  logic         idle;
  logic         len_ok;
  logic         boot_ok;

  assign idle     = (state == HALT) || (state == RUN);
  assign len_ok   = (ld_len != '0) && (ld_len <= MAX_LEN);
  assign boot_ok  = boot_req && idle && len_ok;
  assign xfer     = (state == LOAD) && bus.ld_valid;
  assign next_cnt = {1'b0, word_idx} + (N-1)'(1);
  assign busy     = (state == LOAD) || (state == WRITE);

  imem_word_assembler u_asm (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (boot_ok),
    .xfer  (xfer),
    .data  (bus.ld_data),
    .word  (word),
    .last  (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= HALT;
      word_idx <= '0;
      len_q    <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        HALT, RUN: begin
          if (boot_req) begin
            if (len_ok) begin
              state    <= LOAD;
              word_idx <= '0;
              len_q    <= ld_len;
              err      <= 1'b0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (last) state <= WRITE;
        end
        WRITE: begin
          if (next_cnt == len_q) begin
            state <= RUN;
            done  <= 1'b1;
          end else begin
            word_idx <= word_idx + W'(1);
            state    <= LOAD;
          end
        end
        default: state <= HALT;
      endcase
    end
  end

  // Fetch path is purely combinational so RUN adds no latency.
  always_comb begin
    bus.ld_ready  = (state == LOAD);
    bus.mem_we    = (state == WRITE);
    bus.mem_wd    = '0;
    bus.mem_a     = '0;
    bus.cpu_rst_n = (state == RUN);
    bus.cpu_instr = NOP;
    if (state == WRITE) begin
      bus.mem_a  = {word_idx, 2'b00};
      bus.mem_wd = word;
    end else if (state == RUN) begin
      bus.mem_a     = bus.cpu_pc;
      bus.cpu_instr = bus.mem_rd;
    end
  end

endmodule

// File: tb/tb_imem_boot_controller.sv
// Randomized bench for imem_boot_controller against a
// queue-based reference model of the boot/load protocol.
module tb_imem_boot_controller;
  localparam int N = 8;
  localparam int WORDS = 64;
  localparam logic [31:0] NOP = 32'h00000013;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         boot_req = 1'b0;
  logic [N-2:0] ld_len = '0;
  logic         busy;
  logic         done;
  logic         err;

  imem_boot_controller_if #(.N(N)) bus ();

  imem_boot_controller #(.N(N), .NOP(NOP)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .boot_req (boot_req),
    .ld_len   (ld_len),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  logic [31:0] tbmem [WORDS];
  assign bus.mem_rd = tbmem[bus.mem_a[N-1:2]];
  always @(posedge clk) if (bus.mem_we) tbmem[bus.mem_a[N-1:2]] = bus.mem_wd;

  int npass = 0;
  int nchk = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a load is a byte queue drained four at a time.
  bit          m_active = 0;
  bit          m_run = 0;
  bit          m_done = 0;
  bit          m_err = 0;
  logic [7:0]  m_q[$];
  int          m_nw = 0;
  int          m_len = 0;
  logic [31:0] m_mem [WORDS];

  function automatic logic [31:0] m_word();
    return {m_q[3], m_q[2], m_q[1], m_q[0]};
  endfunction

  function automatic bit m_wr();
    return m_active && m_q.size() == 4;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_run = 0; m_done = 0; m_err = 0;
      m_q.delete(); m_nw = 0; m_len = 0;
    end else begin
      m_done = 0;
      if (m_wr()) begin
        m_mem[m_nw] = m_word();
        m_nw++;
        m_q.delete();
        if (m_nw == m_len) begin
          m_active = 0; m_run = 1; m_done = 1;
        end
      end else if (m_active) begin
        if (bus.ld_valid) m_q.push_back(bus.ld_data);
      end else if (boot_req) begin
        if (ld_len >= 1 && ld_len <= WORDS) begin
          m_active = 1; m_run = 0; m_len = int'(ld_len);
          m_nw = 0; m_q.delete(); m_err = 0;
        end else begin
          m_err = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [31:0] e_wd;
    logic [N-1:0] e_a;
    e_wd = m_wr() ? m_word() : 32'd0;
    e_a  = m_wr() ? N'(m_nw * 4) : (m_run ? bus.cpu_pc : '0);
    chk("ld_ready", bus.ld_ready, m_active && !m_wr());
    chk("mem_we", bus.mem_we, m_wr());
    chk("mem_wd", bus.mem_wd, e_wd);
    chk("mem_a", bus.mem_a, e_a);
    chk("cpu_rst_n", bus.cpu_rst_n, m_run);
    chk("cpu_instr", bus.cpu_instr,
        m_run ? m_mem[bus.cpu_pc[N-1:2]] : NOP);
    chk("busy", busy, m_active);
    chk("done", done, m_done);
    chk("err", err, m_err);
  end

  int nxfer = 0;
  int ndone = 0;
  int wr_ready = 0;
  logic [N-1:0] last_wa = '0;
  always @(negedge clk) begin
    if (bus.ld_valid && bus.ld_ready) nxfer++;
    if (done) ndone++;
    if (bus.mem_we) begin
      last_wa = bus.mem_a;
      if (bus.ld_ready) wr_ready++;
    end
  end

  logic [7:0] src[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic boot(input int len);
    boot_req = 1'b1;
    ld_len = len[N-2:0];
    tick();
    boot_req = 1'b0;
  endtask

  task automatic feed(input int mode, input bit stray);
    int guard = 0;
    bit ph = 0;
    bit x;
    while (src.size() > 0 && guard < 4000) begin
      case (mode)
        0: bus.ld_valid = 1'($urandom_range(0, 1));
        1: begin bus.ld_valid = ph; ph = !ph; end
        default: bus.ld_valid = 1'b1;
      endcase
      bus.ld_data = src[0];
      bus.cpu_pc = N'($urandom);
      boot_req = stray && guard == 3;
      ld_len = (N-1)'($urandom);
      x = bus.ld_valid && bus.ld_ready;
      tick();
      if (x) void'(src.pop_front());
      guard++;
    end
    bus.ld_valid = 1'b0;
    boot_req = 1'b0;
    chk("feed_bound", 32'(guard < 4000), 32'd1);
  endtask

  task automatic wait_idle();
    int g = 0;
    while (busy && g < 50) begin
      tick();
      g++;
    end
    chk("idle_bound", 32'(g < 50), 32'd1);
    tick();
  endtask

  task automatic rand_bytes(input int n);
    src.delete();
    for (int i = 0; i < n; i++) src.push_back(8'($urandom));
  endtask

  initial begin
    logic [31:0] last_word;
    for (int i = 0; i < WORDS; i++) begin
      tbmem[i] = $urandom;
      m_mem[i] = tbmem[i];
    end
    bus.ld_valid = 1'b0;
    bus.ld_data = '0;
    bus.cpu_pc = '0;
    repeat (3) tick();
    chk("rst_ld_ready", bus.ld_ready, 1'b0);
    chk("rst_cpu_rst_n", bus.cpu_rst_n, 1'b0);
    chk("rst_instr", bus.cpu_instr, 32'h00000013);
    rst_n = 1'b1;
    tick();
    bus.cpu_pc = 8'h44;
    #1;
    chk("halt_instr", bus.cpu_instr, 32'h00000013);

    ndone = 0;
    boot(2);
    src = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    feed(2, 0);
    wait_idle();
    chk("boot_w0", tbmem[0], 32'h00000013);
    chk("boot_w1", tbmem[1], 32'h00100093);
    chk("boot_done_cnt", ndone, 32'd1);
    chk("boot_run", bus.cpu_rst_n, 1'b1);
    bus.cpu_pc = 8'd4;
    #1;
    chk("run_fetch", bus.cpu_instr, 32'h00100093);

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    boot(0);
    chk("len0_err", err, 1'b1);
    chk("len0_halt", busy, 1'b0);
    boot(65);
    chk("len65_err", err, 1'b1);
    chk("len65_halt", busy, 1'b0);
    boot(1);
    chk("legal_clears_err", err, 1'b0);
    nxfer = 0;
    wr_ready = 0;
    rand_bytes(4);
    feed(1, 0);
    wait_idle();
    chk("toggle_xfers", nxfer, 32'd4);
    chk("write_ready_low", wr_ready, 32'd0);

    ndone = 0;
    boot(3);
    src = '{8'hef, 8'hbe, 8'had, 8'hde, 8'h11, 8'h22};
    feed(2, 0);
    rst_n = 1'b0;
    #1;
    chk("abort_cpu_rst_n", bus.cpu_rst_n, 1'b0);
    chk("abort_busy", busy, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("abort_no_done", ndone, 32'd0);
    chk("abort_w0", tbmem[0], 32'hdeadbeef);
    chk("abort_w1", tbmem[1], 32'h00100093);

    ndone = 0;
    boot(64);
    rand_bytes(256);
    last_word = {src[255], src[254], src[253], src[252]};
    feed(0, 1);
    wait_idle();
    chk("full_last_addr", last_wa, 32'd252);
    chk("full_done_cnt", ndone, 32'd1);
    chk("full_err_kept", err, 1'b0);
    chk("full_last_word", tbmem[63], last_word);
    repeat (20) begin
      bus.cpu_pc = N'($urandom);
      tick();
    end

    repeat (6) begin
      int len;
      len = $urandom_range(1, 8);
      boot(len);
      rand_bytes(4 * len);
      feed(0, 1'($urandom_range(0, 1)));
      wait_idle();
      repeat (10) begin
        bus.cpu_pc = N'($urandom);
        if ($urandom_range(0, 4) == 0) boot($urandom_range(0, 1) ? 0 : 100);
        else tick();
      end
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
